// File: rtl/pll_reset_seq_pkg.sv
// Shared clocking package: sequencer state codes and small helpers used by
// the PLL reset sequencer and by any status/debug register that decodes it.
package pll_reset_seq_pkg;

  // Sequencer state codes; the numeric values are visible on the state port
  // and are decoded by software-facing status registers.
  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAITLK = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } pll_seq_state_e;

  // Event counters stick at this value.
  localparam logic [7:0] EVT_CNT_MAX = 8'hFF;

  // Largest of three integers.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Width of the shared cycle counter: one spare bit above what the longest
  // dwell needs, so a terminal value never aliases to zero.
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

  // Saturating increment for the 8-bit event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == EVT_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// Two-flop synchronizer for a single slow-changing asynchronous level.
// Both flops clear to 0 on the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next values: first stage samples the async input, second stage the first.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops; reset forces the output to "not locked".
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer. Pulses the PLL reset, waits for lock (with retry on
// timeout), requires a run of consecutive locked cycles, then releases the
// reset of the PLL-clocked domain. Lock loss while running restarts the
// sequence. The PLL itself is instantiated beside this block, not inside it.
//
// Handshake/timing contract: pll_locked is a level, not a valid/ready pair.
// It is synchronized (2 cycles) before use; every output is a flop whose
// next value is derived from the next FSM state, so outputs change on the
// same edge as the state port and never combinationally follow pll_locked.
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int STABLE_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] loss_count,
  output logic [7:0] timeout_count
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an N-cycle dwell sees N-1.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronized lock flag; the only form of pll_locked used below.
  logic lk;

  pll_seq_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_q, loss_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // Next-state, shared cycle counter, event counters and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    loss_d  = loss_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      PLLRST: begin
        // Lock is ignored while the PLL is held in reset.
        if (cnt_q == RST_LAST) begin
          state_d = WAITLK;
          cnt_d   = '0;
        end
      end

      WAITLK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lk) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = PLLRST;
          cnt_d   = '0;
          tmo_d   = sat_inc8(tmo_q);
        end
      end

      STABLE: begin
        // Any unlocked cycle breaks the run; retry the wait without
        // counting it as a timeout.
        if (!lk) begin
          state_d = WAITLK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end

      RUN: begin
        // Counter is idle here; hold it at zero.
        cnt_d = '0;
        if (!lk) begin
          state_d = PLLRST;
          loss_d  = sat_inc8(loss_q);
        end
      end

      default: begin
        state_d = PLLRST;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the state being entered so they line up with state_q.
    pll_rst_d = (state_d == PLLRST);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLLRST;
      cnt_q     <= '0;
      loss_q    <= 8'd0;
      tmo_q     <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      tmo_q     <= tmo_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign loss_count    = loss_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with short dwell parameters. The driver issues one
// input vector per cycle and pushes the reference model's predicted outputs;
// a monitor pops and compares one entry after every clock edge.
module tb_pll_reset_seq;

  localparam int P  = 4;
  localparam int LT = 20;
  localparam int SC = 8;

  localparam int PH_PLLRST = 0;
  localparam int PH_WAITLK = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] loss_count;
  logic [7:0] timeout_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [20:0] exp_q[$];

  // Reference model: phase, dwell time, lock run, events, lock delay line.
  int   m_phase;
  int   m_dwell;
  int   m_run;
  int   m_loss;
  int   m_to;
  logic m_hist[$];

  pll_reset_seq #(
    .PLL_RST_CYCLES (P),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .state         (state),
    .loss_count    (loss_count),
    .timeout_count (timeout_count)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // One clock edge of the behavioural sequencer.
  task automatic model_step(input logic r, input logic pl);
    logic lk;
    if (r) begin
      m_phase = PH_PLLRST;
      m_dwell = 0;
      m_run   = 0;
      m_loss  = 0;
      m_to    = 0;
      m_hist.delete();
      m_hist.push_back(1'b0);
      m_hist.push_back(1'b0);
      return;
    end
    lk = m_hist.pop_front();
    m_hist.push_back(pl);
    case (m_phase)
      PH_PLLRST: begin
        if (m_dwell + 1 == P) begin m_phase = PH_WAITLK; m_dwell = 0; end
        else m_dwell++;
      end
      PH_WAITLK: begin
        if (lk) begin m_phase = PH_STABLE; m_dwell = 0; m_run = 0; end
        else if (m_dwell + 1 == LT) begin
          m_phase = PH_PLLRST; m_dwell = 0; m_to = sat255(m_to + 1);
        end else m_dwell++;
      end
      PH_STABLE: begin
        if (!lk) begin m_phase = PH_WAITLK; m_dwell = 0; m_run = 0; end
        else if (m_run + 1 == SC) begin m_phase = PH_RUN; m_run = 0; end
        else m_run++;
      end
      default: begin
        if (!lk) begin m_phase = PH_PLLRST; m_dwell = 0; m_loss = sat255(m_loss + 1); end
      end
    endcase
  endtask

  function automatic logic [20:0] model_vec();
    return {m_phase == PH_PLLRST, m_phase != PH_RUN, m_phase == PH_RUN,
            2'(m_phase), 8'(m_loss), 8'(m_to)};
  endfunction

  // Drive one cycle of inputs, predict the outputs after the next edge.
  task automatic drive(input logic r, input logic pl);
    @(negedge clk);
    rst        = r;
    pll_locked = pl;
    model_step(r, pl);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_rst"}, sys_rst, 1);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_state"}, state, PH_PLLRST);
    chk({tag, "_loss"}, loss_count, 0);
    chk({tag, "_timeouts"}, timeout_count, 0);
  endtask

  // Scoreboard monitor: compare every output after each edge.
  always @(posedge clk) begin : monitor
    logic [20:0] e;
    logic [20:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pll_rst, sys_rst, ready, state, loss_count, timeout_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d got pll_rst=%0b sys_rst=%0b ready=%0b state=%0d loss=%0d tmo=%0d exp pll_rst=%0b sys_rst=%0b ready=%0b state=%0d loss=%0d tmo=%0d",
                 cyc, a[20], a[19], a[18], a[17:16], a[15:8], a[7:0],
                 e[20], e[19], e[18], e[17:16], e[15:8], e[7:0]);
      end
    end
  end

  // Stimulus
  initial begin : stim
    int hi_cnt;
    int rdy_at;
    int sys_fall;
    int steps;
    int to_before;
    int hold;
    logic pl;

    // Reset state
    repeat (3) drive(1'b1, 1'b0);
    chk_reset_values("reset");

    // Release; lock from cycle 10 (first sampled at edge 11)
    hi_cnt   = 1;
    rdy_at   = -1;
    sys_fall = -1;
    for (int k = 1; k <= 30; k++) begin
      drive(1'b0, k >= 11);
      if (pll_rst) hi_cnt++;
      if (ready && rdy_at < 0) rdy_at = k;
      if (!sys_rst && sys_fall < 0) sys_fall = k;
    end
    chk("pll_rst_pulse_len", hi_cnt, P);
    chk("ready_rise_cycle", rdy_at, 10 + 2 + SC + 1);
    chk("sys_rst_fall_cycle", sys_fall, 10 + 2 + SC + 1);

    // Lock loss in RUN
    repeat (3) drive(1'b0, 1'b0);
    chk("loss_sys_rst", sys_rst, 1);
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_count_1", loss_count, 1);
    steps = 0;
    while (!(m_phase == PH_RUN) && steps < 100) begin drive(1'b0, 1'b1); steps++; end
    chk("relock_ready", ready, 1);

    // Reset while in RUN
    drive(1'b1, 1'b1);
    chk_reset_values("rst_in_run");

    // One-cycle glitch at stable count 5
    steps = 0;
    while (!(m_phase == PH_STABLE && m_run == 3) && steps < 60) begin
      drive(1'b0, 1'b1); steps++;
    end
    chk("reached_stable", m_phase, PH_STABLE);
    drive(1'b0, 1'b0);
    rdy_at = -1;
    for (int k = 1; k <= 30; k++) begin
      drive(1'b0, 1'b1);
      if (ready && rdy_at < 0) rdy_at = k;
    end
    chk("glitch_recover_steps", rdy_at, 2 + 1 + SC);

    // Lock arriving exactly on the last timeout cycle
    steps = 0;
    while (!(m_phase == PH_WAITLK && m_dwell == LT - 3) && steps < 100) begin
      drive(1'b0, 1'b0); steps++;
    end
    to_before = m_to;
    repeat (3) drive(1'b0, 1'b1);
    chk("late_lock_state", state, PH_STABLE);
    chk("late_lock_timeouts", timeout_count, to_before);

    // Lock never arrives: retries every P+LT cycles, count saturates
    repeat (256 * (P + LT) + 40) drive(1'b0, 1'b0);
    chk("timeout_saturated", timeout_count, 255);

    // Reset while in WAITLK
    steps = 0;
    while (m_phase != PH_WAITLK && steps < 40) begin drive(1'b0, 1'b0); steps++; end
    chk("in_waitlk", state, PH_WAITLK);
    drive(1'b1, 1'b0);
    chk_reset_values("rst_in_waitlk");

    // Repeated lock loss: loss counter saturates
    for (int i = 0; i < 260; i++) begin
      steps = 0;
      while (m_phase != PH_RUN && steps < 80) begin drive(1'b0, 1'b1); steps++; end
      repeat (3) drive(1'b0, 1'b0);
    end
    chk("loss_saturated", loss_count, 255);

    // Random lock behaviour with occasional reset
    hold = 0;
    pl   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pl   = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 30);
      end
      hold--;
      drive($urandom_range(0, 299) == 0, pl);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
